// File: rtl/multicycle_main_controller.sv
// Multicycle RISC-V main control FSM: Moore outputs per state, branch PCWrite from func3/flags.
// Optional MC_ILLEGAL_TRAP_EN: ILLEGAL state holds until reset instead of returning to FETCH.
module multicycle_main_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       neg,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       illegal
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR, JALRPC, LUI, ILLEGAL
  } state_t;

  state_t state, state_nxt;
  logic   take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    case (func3)
      3'b000:  take = zero;
      3'b001:  take = ~zero;
      3'b100:  take = neg;
      3'b101:  take = ~neg;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 2'b00;
    ImmSrc    = 3'b000;
    illegal   = 1'b0;
    case (state)
      FETCH: begin
        IRWrite = 1'b1; PCWrite = 1'b1;
        ALUSrcB = 2'b10; ResultSrc = 2'b10;
        state_nxt = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_R:         state_nxt = EXECR;
          OP_I:         state_nxt = EXECI;
          OP_B:         state_nxt = BRANCH;
          OP_JAL:       state_nxt = JAL;
          OP_JALR:      state_nxt = JALR;
          OP_LUI:       state_nxt = LUI;
          default:      state_nxt = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01;
        state_nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        state_nxt = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01; RegWrite = 1'b1;
        state_nxt = FETCH;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1; MemWrite = 1'b1;
        state_nxt = FETCH;
      end
      EXECR: begin
        ALUSrcA = 2'b10; ALUOp = 2'b10;
        state_nxt = ALUWB;
      end
      EXECI: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUOp = 2'b11;
        state_nxt = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        state_nxt = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 2'b10; ALUOp = 2'b01;
        PCWrite = take;
        state_nxt = FETCH;
      end
      JAL, JALRPC: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1;
        state_nxt = ALUWB;
      end
      JALR: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01;
        state_nxt = JALRPC;
      end
      LUI: begin
        ResultSrc = 2'b11; RegWrite = 1'b1;
        state_nxt = FETCH;
      end
      default: begin
        illegal = 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
        state_nxt = ILLEGAL;
`else
        state_nxt = FETCH;
`endif
      end
    endcase

    case (op)
      OP_SW:   ImmSrc = 3'b001;
      OP_B:    ImmSrc = 3'b010;
      OP_JAL:  ImmSrc = 3'b011;
      OP_LUI:  ImmSrc = 3'b100;
      default: ImmSrc = 3'b000;
    endcase

    // Reset gates every output asynchronously, not just the state register,
    // since FETCH itself drives write enables.
    if (!rst_n) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      ALUOp     = 2'b00;
      ImmSrc    = 3'b000;
      illegal   = 1'b0;
    end
  end

endmodule
